// File: rtl/player_turn_ctrl_pkg.sv
// Shared game types and constants for the player turn controller.
// The helper function maps a card rank to its hard blackjack points.
package player_turn_ctrl_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        HIT   = 2'd1,
        STAND = 2'd2
    } gameCommand;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEAL     = 3'd1,
        ARM      = 3'd2,
        WAIT_CMD = 3'd3,
        DRAW     = 3'd4,
        DONE     = 3'd5
    } turn_state_t;

    localparam int BLACKJACK_LIMIT = 21;
    localparam int ACE_BONUS       = 10;

    // Aces count 1 here; the soft +10 is applied from the ace flag.
    // Face cards and out-of-range ranks are worth 10.
    function automatic logic [4:0] card_points(input logic [3:0] rank);
        if (rank == 4'd0 || rank >= 4'd11) begin
            return 5'd10;
        end
        return {1'b0, rank};
    endfunction

endpackage

// File: rtl/player_turn_ctrl_hand.sv
// Hand accumulator: hard sum, ace flag and card count with clear/add.
// Outputs describe the hand including any card being added this cycle.
module hand_accumulator
    import player_turn_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [3:0] i_rank,
    output logic [4:0] o_total,
    output logic [3:0] o_count,
    output logic       o_bust,
    output logic       o_blackjack
);

    logic [4:0] r_hard;
    logic       r_ace;
    logic [3:0] r_count;

    logic [4:0] w_hard_next;
    logic       w_ace_next;
    logic [3:0] w_count_next;
    logic [5:0] w_soft;

    always_comb begin
        w_hard_next  = r_hard;
        w_ace_next   = r_ace;
        w_count_next = r_count;
        if (i_clear) begin
            w_hard_next  = 5'd0;
            w_ace_next   = 1'b0;
            w_count_next = 4'd0;
        end else if (i_add) begin
            w_hard_next  = r_hard + card_points(i_rank);
            w_ace_next   = r_ace | (i_rank == 4'd1);
            w_count_next = (r_count == 4'd15) ? 4'd15 : r_count + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hard  <= 5'd0;
            r_ace   <= 1'b0;
            r_count <= 4'd0;
        end else begin
            r_hard  <= w_hard_next;
            r_ace   <= w_ace_next;
            r_count <= w_count_next;
        end
    end

    // Soft value is computed one bit wider so a large hard sum cannot wrap.
    assign w_soft      = {1'b0, w_hard_next} + 6'(ACE_BONUS);
    assign o_total     = (w_ace_next && w_soft <= 6'(BLACKJACK_LIMIT)) ? w_soft[4:0] : w_hard_next;
    assign o_count     = w_count_next;
    assign o_bust      = w_hard_next > 5'(BLACKJACK_LIMIT);
    assign o_blackjack = (o_total == 5'(BLACKJACK_LIMIT)) && (w_count_next == 4'd2);

endmodule

// File: rtl/player_turn_ctrl.sv
// Player turn controller: deals opening cards, turns distinct button presses
// into HIT/STAND actions and ends the turn on stand, bust or 21.
module player_turn_ctrl
    import player_turn_ctrl_pkg::*;
#(
    parameter int unsigned INITIAL_CARDS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_turn,
    input  logic       ready,
    input  gameCommand command,
    output logic       turn_indicator,
    output logic       card_req,
    input  logic       card_ack,
    input  logic [3:0] card_value,
    output logic [4:0] hand_total,
    output logic [3:0] card_count,
    output logic       bust,
    output logic       blackjack,
    output logic       turn_done
);

    localparam logic [2:0] LP_INIT_CARDS = 3'(INITIAL_CARDS);

    turn_state_t r_state;
    turn_state_t w_state_next;
    logic [2:0]  r_deal_cnt;
    logic [2:0]  w_deal_cnt_next;
    logic        r_card_req;
    logic        w_req_next;
    logic        r_turn_indicator;
    logic        r_turn_done;
    logic [4:0]  r_hand_total;
    logic [3:0]  r_card_count;
    logic        r_bust;
    logic        r_blackjack;

    logic        w_clear;
    logic        w_add;
    logic [4:0]  w_total;
    logic [3:0]  w_count;
    logic        w_bust;
    logic        w_blackjack;
    logic        w_turn_over;

    hand_accumulator u_hand (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .i_add       (w_add),
        .i_rank      (card_value),
        .o_total     (w_total),
        .o_count     (w_count),
        .o_bust      (w_bust),
        .o_blackjack (w_blackjack)
    );

    // Valid in the ack cycle: reflects the hand after the incoming card.
    assign w_turn_over = w_bust || (w_total == 5'(BLACKJACK_LIMIT));

    always_comb begin
        w_state_next    = r_state;
        w_deal_cnt_next = r_deal_cnt;
        w_req_next      = 1'b0;
        w_clear         = 1'b0;
        w_add           = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_turn) begin
                    w_clear         = 1'b1;
                    w_deal_cnt_next = 3'd0;
                    w_req_next      = 1'b1;
                    w_state_next    = DEAL;
                end
            end
            DEAL: begin
                if (!r_card_req) begin
                    w_req_next = 1'b1;
                end else if (card_ack) begin
                    w_add           = 1'b1;
                    w_deal_cnt_next = r_deal_cnt + 3'd1;
                    if (w_turn_over) begin
                        w_state_next = DONE;
                    end else if (r_deal_cnt + 3'd1 == LP_INIT_CARDS) begin
                        w_state_next = ARM;
                    end
                end else begin
                    w_req_next = 1'b1;
                end
            end
            ARM: begin
                if (!ready) begin
                    w_state_next = WAIT_CMD;
                end
            end
            WAIT_CMD: begin
                if (ready) begin
                    if (command == HIT) begin
                        w_req_next   = 1'b1;
                        w_state_next = DRAW;
                    end else if (command == STAND) begin
                        w_state_next = DONE;
                    end
                end
            end
            DRAW: begin
                if (r_card_req && card_ack) begin
                    w_add        = 1'b1;
                    w_state_next = w_turn_over ? DONE : ARM;
                end else begin
                    w_req_next = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_deal_cnt       <= 3'd0;
            r_card_req       <= 1'b0;
            r_turn_indicator <= 1'b0;
            r_turn_done      <= 1'b0;
            r_hand_total     <= 5'd0;
            r_card_count     <= 4'd0;
            r_bust           <= 1'b0;
            r_blackjack      <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_deal_cnt       <= w_deal_cnt_next;
            r_card_req       <= w_req_next;
            r_turn_indicator <= (w_state_next == ARM) || (w_state_next == WAIT_CMD);
            r_turn_done      <= (w_state_next == DONE);
            r_hand_total     <= w_total;
            r_card_count     <= w_count;
            r_bust           <= w_bust;
            r_blackjack      <= w_blackjack;
        end
    end

    assign turn_indicator = r_turn_indicator;
    assign card_req       = r_card_req;
    assign turn_done      = r_turn_done;
    assign hand_total     = r_hand_total;
    assign card_count     = r_card_count;
    assign bust           = r_bust;
    assign blackjack      = r_blackjack;

endmodule

// File: tb/tb_player_turn_ctrl.sv
// Directed bench for player_turn_ctrl: deck handshakes, button sequencing,
// hand arithmetic and reset behaviour with hand-computed expectations.
module tb_player_turn_ctrl;
    import player_turn_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_turn = 1'b0;
    logic       ready = 1'b0;
    gameCommand command = NONE;
    logic       turn_indicator;
    logic       card_req;
    logic       card_ack = 1'b0;
    logic [3:0] card_value = 4'd0;
    logic [4:0] hand_total;
    logic [3:0] card_count;
    logic       bust;
    logic       blackjack;
    logic       turn_done;

    int n_checks = 0;
    int n_errors = 0;

    player_turn_ctrl #(.INITIAL_CARDS(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_turn     (start_turn),
        .ready          (ready),
        .command        (command),
        .turn_indicator (turn_indicator),
        .card_req       (card_req),
        .card_ack       (card_ack),
        .card_value     (card_value),
        .hand_total     (hand_total),
        .card_count     (card_count),
        .bust           (bust),
        .blackjack      (blackjack),
        .turn_done      (turn_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s = %0d", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_turn = 1'b1;
        tick();
        start_turn = 1'b0;
    endtask

    // Deck model: wait for a request, hold off ack for 'delay' cycles, then ack once.
    task automatic serve(input logic [3:0] v, input int delay);
        int n = 0;
        while (!card_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 32'(card_req), 32'd1);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("req_held", 32'(card_req), 32'd1);
        end
        card_ack   = 1'b1;
        card_value = v;
        tick();
        card_ack   = 1'b0;
        card_value = 4'd0;
        check("req_drop", 32'(card_req), 32'd0);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({turn_indicator, card_req, hand_total, card_count, bust, blackjack, turn_done});
    endfunction

    initial begin
        #2;
        check("reset_outs", all_outs(), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Natural blackjack: ace then king.
        pulse_start();
        check("bj_req_next", 32'(card_req), 32'd1);
        serve(4'd1, 0);
        check("bj_total1", 32'(hand_total), 32'd11);
        check("bj_ind_deal", 32'(turn_indicator), 32'd0);
        serve(4'd13, 0);
        check("bj_total", 32'(hand_total), 32'd21);
        check("bj_flag", 32'(blackjack), 32'd1);
        check("bj_done", 32'(turn_done), 32'd1);
        check("bj_ind", 32'(turn_indicator), 32'd0);
        tick();
        check("bj_done_clr", 32'(turn_done), 32'd0);
        check("bj_hold", 32'(hand_total), 32'd21);

        // Held key across ARM entry must not trigger; then HIT 9 busts.
        pulse_start();
        check("hb_clear", 32'(card_count), 32'd0);
        serve(4'd10, 0);
        ready   = 1'b1;
        command = HIT;
        serve(4'd6, 0);
        check("hb_total16", 32'(hand_total), 32'd16);
        check("hb_ind_arm", 32'(turn_indicator), 32'd1);
        repeat (3) begin
            tick();
            check("hb_no_draw", 32'(card_req), 32'd0);
        end
        ready = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready   = 1'b0;
        command = NONE;
        check("hb_hit_req", 32'(card_req), 32'd1);
        check("hb_hit_ind", 32'(turn_indicator), 32'd0);
        serve(4'd9, 0);
        check("hb_total25", 32'(hand_total), 32'd25);
        check("hb_bust", 32'(bust), 32'd1);
        check("hb_done", 32'(turn_done), 32'd1);
        tick();

        // Soft hand demoted by a ten, stray ack, ignored start, slow deck, stand.
        pulse_start();
        serve(4'd1, 0);
        serve(4'd5, 0);
        check("sa_soft16", 32'(hand_total), 32'd16);
        tick();
        card_ack   = 1'b1;
        card_value = 4'd5;
        tick();
        card_ack   = 1'b0;
        card_value = 4'd0;
        check("sa_stray_cnt", 32'(card_count), 32'd2);
        check("sa_stray_tot", 32'(hand_total), 32'd16);
        pulse_start();
        check("sa_ign_start", 32'(card_count), 32'd2);
        check("sa_ign_req", 32'(card_req), 32'd0);
        ready   = 1'b1;
        command = HIT;
        tick();
        ready   = 1'b0;
        command = NONE;
        serve(4'd10, 5);
        check("sa_demoted", 32'(hand_total), 32'd16);
        check("sa_nobust", 32'(bust), 32'd0);
        check("sa_count3", 32'(card_count), 32'd3);
        check("sa_back_arm", 32'(turn_indicator), 32'd1);
        tick();
        ready   = 1'b1;
        command = STAND;
        tick();
        ready   = 1'b0;
        command = NONE;
        check("st_done", 32'(turn_done), 32'd1);
        check("st_ind", 32'(turn_indicator), 32'd0);
        tick();
        check("st_done_clr", 32'(turn_done), 32'd0);
        check("st_hold", 32'(hand_total), 32'd16);

        // Reset while a draw request is outstanding.
        pulse_start();
        serve(4'd2, 0);
        serve(4'd3, 0);
        tick();
        ready   = 1'b1;
        command = HIT;
        tick();
        ready   = 1'b0;
        command = NONE;
        check("rs_req_up", 32'(card_req), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rs_async_outs", all_outs(), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start();
        check("rs_restart_req", 32'(card_req), 32'd1);
        serve(4'd4, 0);
        serve(4'd5, 0);
        check("rs_total9", 32'(hand_total), 32'd9);
        check("rs_count2", 32'(card_count), 32'd2);
        check("rs_ind", 32'(turn_indicator), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/player_turn_ctrl.md
# player_turn_ctrl

Sequential consumer of the player's `gameCommand` stream and the owner of the `turnIndicator` signal that the button-input block qualifies. It runs one player turn:
- deals the opening cards from the deck block;
- arms for a button choice and converts each distinct press into exactly one action (HIT draws a card, STAND ends the turn);
- keeps the running blackjack hand value and ends the turn on bust or 21.

It sits between the top-level game FSM, the button-input block and the card deck.

## Interface
Parameters:
- `INITIAL_CARDS`, default 2, cards dealt automatically at turn start (1..4).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_turn`  in  1  one-cycle pulse from game FSM; starts a turn.
- `ready`  in  1  button-input "my turn and a key is down".
- `command`  in  gameCommand  NONE/HIT/STAND from button-input block.
- `turn_indicator`  out  1  high only while waiting for a player choice.
- `card_req`  out  1  request one card from deck.
- `card_ack`  in  1  deck response; `card_value` valid this cycle.
- `card_value`  in  4  card rank 1..13 (1=ace, 11..13 face).
- `hand_total`  out  5  best hand value, 0..31.
- `card_count`  out  4  cards in hand, saturates at 15.
- `bust`  out  1  hand hard total > 21.
- `blackjack`  out  1  total 21 with exactly 2 cards.
- `turn_done`  out  1  one-cycle pulse at turn end.

## Operation
- States: IDLE, DEAL, ARM, WAIT_CMD, DRAW, DONE.
- IDLE:
  - `start_turn` clears the hand (hard sum, ace flag, count, bust, blackjack) and goes to DEAL.
  - `start_turn` in any other state is ignored.
- DEAL: performs `INITIAL_CARDS` card handshakes back-to-back, then goes to ARM. If the total reaches 21 or busts before all cards are dealt, it stops dealing and goes to DONE.
- ARM:
  - `turn_indicator` = 1.
  - Waits for `ready` = 0 (all keys released), then goes to WAIT_CMD.
  - A key held over from a previous action never triggers.
- WAIT_CMD:
  - `turn_indicator` = 1.
  - On `ready` = 1: command HIT goes to DRAW; STAND goes to DONE; NONE stays in WAIT_CMD.
- DRAW: one card handshake. After the add: bust or total == 21 goes to DONE, otherwise ARM.
- DONE: `turn_done` = 1 for one cycle, then IDLE. Hand outputs hold until the next `start_turn`.
- Card handshake:
  - `card_req` is held high until the cycle `card_ack` = 1.
  - `card_value` is sampled in that cycle.
  - `card_req` is low the following cycle.
  - `card_req` is low for at least one cycle between cards.
  - `card_ack` while `card_req` = 0 is ignored.
- Arithmetic:
  - Rank maps to points: 1 → 1 (sets ace flag), 2..10 → face value, 11..15 → 10, 0 → 10.
  - Hard sum is 5-bit; it cannot exceed 30 because adding stops at bust.
  - `hand_total` = hard + 10 if the ace flag is set and hard + 10 ≤ 21, else hard.
  - `bust` = hard > 21.
  - `blackjack` = (`hand_total` == 21 && `card_count` == 2).
- Reset (any time, mid-handshake included): state IDLE; all outputs 0. An outstanding request is abandoned, and the deck must tolerate `card_req` dropping.

## Timing
- All outputs are registered.
- `start_turn` at cycle N gives `card_req` = 1 at N+1.
- `card_ack` at cycle M gives:
  - `hand_total`/`card_count`/`bust` updated at M+1;
  - `card_req` low at M+1;
  - next request (DEAL) at M+2.
- Press latency: `ready` with HIT sampled at cycle N gives `turn_indicator` = 0 and `card_req` = 1 at N+1.
- STAND sampled at N gives `turn_indicator` = 0 and `turn_done` = 1 at N+1.
- `turn_indicator` is 0 during DEAL/DRAW, so the input block reports NONE during card fetches.
- No debounce here. One press maps to one action only via the ARM release requirement; upstream debounce is assumed to be a separate block.

## Structure
- Shared game package: `gameCommand` enum (NONE, HIT, STAND), constant `BLACKJACK_LIMIT` = 21, constant `ACE_BONUS` = 10. New state enum `turn_state_t` goes in the package for debug visibility.
- One natural sub-module: `hand_accumulator`. It holds the hard sum, ace flag and count; has a clear/add interface; and produces combinational `hand_total`/`bust`/`blackjack` for registering by the parent.

## Test plan
- Reset during DRAW with `card_req` high → all outputs 0 immediately; after release, `start_turn` deals normally.
- `start_turn`; deck supplies 1, 13 with `card_ack` one cycle after each req → `hand_total` = 21, `blackjack` = 1, `turn_done` pulse, `turn_indicator` never 1.
- Deal 10, 6; hold `ready` = 1/HIT across ARM entry → no draw until `ready` = 0 then 1. Then HIT with card 9 → `hand_total` = 25, `bust` = 1, `turn_done`.
- Deal 1, 5 (`hand_total` 16); HIT card 10 → `hand_total` = 16 (ace demoted), `bust` = 0, back to ARM. STAND → `turn_done` 1 cycle after `ready`, values held.
- Deck delays `card_ack` 5 cycles → `card_req` stays high all 5 cycles, single card counted. Stray `card_ack` in WAIT_CMD → no change.
- `start_turn` asserted in WAIT_CMD → ignored; `card_count` unchanged.
